// File: rtl/regwr_arbiter_pkg.sv
// Shared register-file write constants, requester indices and the address-to-enable decode.
package regwr_arbiter_pkg;

  localparam int RF_ADDR_W = 4;
  localparam int RF_DEPTH  = 16;

  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;
  localparam int WB_MDU  = 2;
  localparam int WB_CP0  = 3;

  // Exact decode: every one of the 16 codes owns its own enable bit.
  function automatic logic [RF_DEPTH-1:0] rf_addr_onehot(input logic [RF_ADDR_W-1:0] addr);
    rf_addr_onehot       = '0;
    rf_addr_onehot[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/regwr_arbiter_rr_pick.sv
// Combinational round-robin search: first eligible index after 'last', wrapping mod NREQ.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  eligible,
  input  logic [IDX_W-1:0] last,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    int c;
    c           = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(last) + k) % NREQ;
      if (!grant_valid && eligible[c]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/regwr_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Build option REGWR_ZERO_SUPPRESS_EN: grants to address 0 still ack but never assert rf_we.
module regwr_arbiter
  import regwr_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [RF_ADDR_W*NREQ-1:0] req_addr,
  input  logic [DATA_W*NREQ-1:0]   req_data,
  input  logic                     wr_hold,
  output logic [NREQ-1:0]          ack,
  output logic [RF_DEPTH-1:0]      rf_we,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [RF_ADDR_W-1:0]     rf_waddr
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      ack_q, ack_d;
  logic [RF_DEPTH-1:0]  we_q, we_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [RF_ADDR_W-1:0] waddr_q, waddr_d;
  logic [IDX_W-1:0]     last_q, last_d;

  logic [NREQ-1:0]      eligible;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;

  // A requester being acked this cycle still shows req high; mask it to avoid a double write.
  assign eligible = req & ~ack_q;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .eligible    (eligible),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    ack_d   = '0;
    we_d    = '0;
    last_d  = last_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    if (!wr_hold && grant_valid) begin
      ack_d   = NREQ'(1) << grant_idx;
      last_d  = grant_idx;
      waddr_d = req_addr[int'(grant_idx)*RF_ADDR_W +: RF_ADDR_W];
      wdata_d = req_data[int'(grant_idx)*DATA_W +: DATA_W];
      we_d    = rf_addr_onehot(waddr_d);
`ifdef REGWR_ZERO_SUPPRESS_EN
      if (waddr_d == '0) we_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q   <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      last_q  <= IDX_W'(NREQ - 1);
    end else begin
      ack_q   <= ack_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      last_q  <= last_d;
    end
  end

  assign ack      = ack_q;
  assign rf_we    = we_q;
  assign rf_wdata = wdata_q;
  assign rf_waddr = waddr_q;

endmodule

// File: tb/tb_regwr_arbiter.sv
// Self-checking bench for regwr_arbiter: directed scenarios plus randomized traffic vs a queue-free reference model.
module tb_regwr_arbiter;
  import regwr_arbiter_pkg::*;

  localparam int NREQ   = 4;
  localparam int DATA_W = 32;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic [NREQ-1:0]           req = '0;
  logic [4*NREQ-1:0]         req_addr;
  logic [DATA_W*NREQ-1:0]    req_data;
  logic                      wr_hold = 1'b0;
  logic [NREQ-1:0]           ack;
  logic [15:0]               rf_we;
  logic [DATA_W-1:0]         rf_wdata;
  logic [3:0]                rf_waddr;

  logic [3:0]        a_arr [NREQ];
  logic [DATA_W-1:0] d_arr [NREQ];

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  int                m_last;
  logic [NREQ-1:0]   m_ack;
  logic [15:0]       m_we;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        m_waddr;

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*4 +: 4]          = a_arr[i];
      req_data[i*DATA_W +: DATA_W] = d_arr[i];
    end
  end

  regwr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .wr_hold  (wr_hold),
    .ack      (ack),
    .rf_we    (rf_we),
    .rf_wdata (rf_wdata),
    .rf_waddr (rf_waddr)
  );

  task automatic model_reset();
    m_last  = NREQ - 1;
    m_ack   = '0;
    m_we    = '0;
    m_wdata = '0;
    m_waddr = '0;
  endtask

  // One clock edge of the arbitration rules: rotate from last+1, skip the just-acked requester.
  task automatic model_edge();
    int win;
    int cand;
    win = -1;
    if (!wr_hold) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = (m_last + k) % NREQ;
        if (win < 0 && req[cand] && !m_ack[cand]) win = cand;
      end
    end
    if (win >= 0) begin
      m_ack   = '0;
      m_ack[win] = 1'b1;
      m_waddr = a_arr[win];
      m_wdata = d_arr[win];
      m_we    = 16'h1 << a_arr[win];
`ifdef REGWR_ZERO_SUPPRESS_EN
      if (a_arr[win] == 4'd0) m_we = 16'h0;
`endif
      m_last  = win;
    end else begin
      m_ack = '0;
      m_we  = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    wr_hold = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (ack !== 4'b0 || rf_we !== 16'h0 || rf_wdata !== 32'h0 || rf_waddr !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset: ack=%b we=%h wdata=%h waddr=%h, need all zero", ack, rf_we, rf_wdata, rf_waddr);
    end
  endtask

  task automatic test_single();
    req      = 4'b0001;
    a_arr[0] = 4'd5;
    d_arr[0] = 32'hDEADBEEF;
    tick();
    tests_run++;
    if (rf_we !== 16'h0020 || rf_wdata !== 32'hDEADBEEF || ack !== 4'b0001 || rf_waddr !== 4'd5) begin
      tests_failed++;
      $display("FAIL single_grant: we=%h wdata=%h ack=%b waddr=%0d, need 0020 deadbeef 0001 5",
               rf_we, rf_wdata, ack, rf_waddr);
    end
    req = '0;
    tick();
    tests_run++;
    if (rf_we !== 16'h0 || ack !== 4'b0) begin
      tests_failed++;
      $display("FAIL single_drop: we=%h ack=%b, need 0 0", rf_we, ack);
    end
  endtask

  task automatic test_all_req();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 4'(i + 1);
      d_arr[i] = $urandom;
    end
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      tick();
      tests_run++;
      if (ack !== 4'(1 << (c % 4)) || rf_we !== 16'(1 << (c % 4 + 1)) || rf_wdata !== d_arr[c % 4]) begin
        tests_failed++;
        $display("FAIL all_req_order c=%0d: ack=%b we=%h wdata=%h, need ack=%b we=%h wdata=%h",
                 c, ack, rf_we, rf_wdata, 4'(1 << (c % 4)), 16'(1 << (c % 4 + 1)), d_arr[c % 4]);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_addr_sweep();
    logic [15:0] exp_we;
    for (int a = 0; a < 16; a++) begin
      req          = '0;
      req[WB_MDU]  = 1'b1;
      a_arr[WB_MDU] = 4'(a);
      d_arr[WB_MDU] = $urandom;
      tick();
      exp_we = 16'h1 << a;
`ifdef REGWR_ZERO_SUPPRESS_EN
      if (a == 0) exp_we = 16'h0;
`endif
      tests_run++;
      if (rf_we !== exp_we || ack !== 4'b0100 || rf_waddr !== 4'(a) || rf_wdata !== d_arr[WB_MDU]) begin
        tests_failed++;
        $display("FAIL addr_sweep a=%0d: we=%h ack=%b waddr=%0d, need we=%h ack=0100 waddr=%0d",
                 a, rf_we, ack, rf_waddr, exp_we, a);
      end
      req = '0;
      tick();
    end
  endtask

  task automatic test_hold();
    logic [DATA_W-1:0] held;
    held     = m_wdata;
    a_arr[1] = 4'd9;  d_arr[1] = $urandom;
    a_arr[2] = 4'd10; d_arr[2] = $urandom;
    wr_hold  = 1'b1;
    req      = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (ack !== 4'b0 || rf_we !== 16'h0 || rf_wdata !== held) begin
        tests_failed++;
        $display("FAIL hold c=%0d: ack=%b we=%h wdata=%h, need 0 0 %h", c, ack, rf_we, rf_wdata, held);
      end
    end
    wr_hold = 1'b0;
    tick();
    tests_run++;
    if (ack !== 4'b0010 || rf_we !== 16'h0200 || rf_wdata !== d_arr[1]) begin
      tests_failed++;
      $display("FAIL hold_first: ack=%b we=%h, need 0010 0200", ack, rf_we);
    end
    req[1] = 1'b0;
    tick();
    tests_run++;
    if (ack !== 4'b0100 || rf_we !== 16'h0400 || rf_wdata !== d_arr[2]) begin
      tests_failed++;
      $display("FAIL hold_second: ack=%b we=%h, need 0100 0400", ack, rf_we);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    req      = 4'b0010;
    a_arr[1] = 4'd7;
    d_arr[1] = $urandom;
    tick();
    tests_run++;
    if (ack !== 4'b0010) begin
      tests_failed++;
      $display("FAIL mid_pre: ack=%b, need 0010", ack);
    end
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 4'(i + 8);
      d_arr[i] = $urandom;
    end
    req = 4'b1111;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (ack !== 4'b0 || rf_we !== 16'h0) begin
      tests_failed++;
      $display("FAIL mid_async: ack=%b we=%h, need 0 0", ack, rf_we);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (ack !== 4'b0001 || rf_we !== 16'h0100) begin
      tests_failed++;
      $display("FAIL mid_first_winner: ack=%b we=%h, need 0001 0100", ack, rf_we);
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && m_ack[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else begin
            a_arr[i] = 4'($urandom_range(0, 15));
            d_arr[i] = $urandom;
          end
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i]   = 1'b1;
          a_arr[i] = 4'($urandom_range(0, 15));
          d_arr[i] = $urandom;
        end
      end
      wr_hold = ($urandom_range(0, 4) == 0);
      tick();
      tests_run++;
      if (ack !== m_ack || rf_we !== m_we || rf_wdata !== m_wdata || rf_waddr !== m_waddr ||
          $countones(ack) > 1 || $countones(rf_we) > 1) begin
        tests_failed++;
        $display("FAIL random c=%0d: ack=%b we=%h wdata=%h waddr=%0d, need ack=%b we=%h wdata=%h waddr=%0d",
                 c, ack, rf_we, rf_wdata, rf_waddr, m_ack, m_we, m_wdata, m_waddr);
      end
    end
    req     = '0;
    wr_hold = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      d_arr[i] = '0;
    end
    test_reset();
    test_single();
    test_all_req();
    test_addr_sweep();
    test_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
